gpr_write_arbiter: RTL and testbench

Shares the single write port of the 8×8-bit general-purpose register file between two writeback requesters: requester 0 is ALU writeback and requester 1 is load writeback. Each requester uses a valid/ready handshake. Requests are granted round-robin, and the winner drives a registered write-port stage connected directly to the register file's write enable, destination and data inputs. A hold input freezes all writes, for register dumps or debug. A saturating counter records write-port contention for performance monitoring.

---
 rtl/gpr_write_arbiter.sv | 131 +++++++++++++
 tb/tb_gpr_write_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_write_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_write_arbiter
//
// Purpose:
//   Shares the single write port of the general-purpose register file between
//   two writeback requesters: requester 0 is ALU writeback and requester 1 is
//   load writeback. The two requesters are granted round-robin. The winner is
//   captured into a registered write stage that drives the register file
//   directly. A hold input freezes all grants. A saturating counter records
//   cycles in which both requesters competed for the port.
//
// Ports:
//   clk             in   system clock, all state updates on the rising edge
//   rst             in   synchronous active-high reset
//   hold            in   1 = block every grant this cycle
//   req0_valid      in   ALU writeback request
//   req0_dest       in   ALU destination register
//   req0_data       in   ALU result
//   req0_ready      out  ALU request accepted this cycle (combinational)
//   req1_valid      in   load writeback request
//   req1_dest       in   load destination register
//   req1_data       in   loaded data
//   req1_ready      out  load request accepted this cycle (combinational)
//   reg_write_en    out  register-file write enable (registered)
//   reg_write_dest  out  register-file write address (registered)
//   reg_write_data  out  register-file write data (registered)
//   last_grant      out  most recently granted requester (registered)
//   contention_cnt  out  saturating count of contended cycles (registered)
// -----------------------------------------------------------------------------
module gpr_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_dest,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_dest,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              last_grant,
  output logic [CNT_W-1:0]  contention_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // 0 = requester 0 is favoured when both are valid.
  logic              r_prio;
  logic              r_write_en;
  logic [ADDR_W-1:0] r_write_dest;
  logic [DATA_W-1:0] r_write_data;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_ready0;
  logic              w_ready1;
  logic              w_xfer0;
  logic              w_xfer1;
  logic              w_xfer;
  logic              w_contended;

  // Ready generation. Each ready looks only at the other requester's valid,
  // never at its own, so no combinational path exists from a requester's
  // valid to its own ready. When a requester is idle its ready is a
  // don't-care because no transfer can happen on it.
  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    if (rst || hold) begin
      w_ready0 = 1'b0;
      w_ready1 = 1'b0;
    end else begin
      w_ready0 = ~req1_valid | (r_prio == 1'b0);
      w_ready1 = ~req0_valid | (r_prio == 1'b1);
    end
  end

  // Transfer qualification; at most one of the two can be set in a cycle.
  always_comb begin
    w_xfer0     = req0_valid & w_ready0;
    w_xfer1     = req1_valid & w_ready1;
    w_xfer      = w_xfer0 | w_xfer1;
    w_contended = req0_valid & req1_valid & ~hold & ~rst;
  end

  // Write stage, priority and grant bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write_en   <= 1'b0;
      r_write_dest <= {ADDR_W{1'b0}};
      r_write_data <= {DATA_W{1'b0}};
      r_last_grant <= 1'b1;
      r_prio       <= 1'b0;
    end else begin
      r_write_en <= w_xfer;
      if (w_xfer) begin
        r_write_dest <= w_xfer1 ? req1_dest : req0_dest;
        r_write_data <= w_xfer1 ? req1_data : req0_data;
        r_last_grant <= w_xfer1;
        r_prio       <= ~w_xfer1;
      end
    end
  end

  // Saturating contention counter for performance monitoring.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_contended && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign req0_ready     = w_ready0;
  assign req1_ready     = w_ready1;
  assign reg_write_en   = r_write_en;
  assign reg_write_dest = r_write_dest;
  assign reg_write_data = r_write_data;
  assign last_grant     = r_last_grant;
  assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpr_write_arbiter
//
// Purpose:
//   Self-checking bench for gpr_write_arbiter. Two instances share the same
//   stimulus: one with the default 8-bit contention counter and one with a
//   3-bit counter to exercise saturation. A behavioural model tracks the
//   expected write stage, priority, counters and register-file contents; a
//   compare process checks both instances against it on every falling edge,
//   and the directed sequence adds hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_gpr_write_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              rst;
  logic              hold;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_dest;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_dest;
  logic [DATA_W-1:0] req1_data;

  logic              a_ready0, a_ready1, a_we, a_lg;
  logic [ADDR_W-1:0] a_dest;
  logic [DATA_W-1:0] a_data;
  logic [7:0]        a_cnt;
  logic              b_ready0, b_ready1, b_we, b_lg;
  logic [ADDR_W-1:0] b_dest;
  logic [DATA_W-1:0] b_data;
  logic [2:0]        b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  gpr_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data),
    .req0_ready(a_ready0),
    .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data),
    .req1_ready(a_ready1),
    .reg_write_en(a_we), .reg_write_dest(a_dest), .reg_write_data(a_data),
    .last_grant(a_lg), .contention_cnt(a_cnt)
  );

  gpr_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data),
    .req0_ready(b_ready0),
    .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data),
    .req1_ready(b_ready1),
    .reg_write_en(b_we), .reg_write_dest(b_dest), .reg_write_data(b_data),
    .last_grant(b_lg), .contention_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, got, got, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Winner of this cycle: -1 = nobody, else requester index.
  function automatic int winner(input logic r, input logic h, input logic v0,
                                input logic v1, input logic p);
    if (r || h)        return -1;
    else if (v0 && v1) return int'(p);
    else if (v0)       return 0;
    else if (v1)       return 1;
    else               return -1;
  endfunction

  logic              m_prio;
  logic              m_we;
  logic [ADDR_W-1:0] m_dest;
  logic [DATA_W-1:0] m_data;
  logic              m_lg;
  int                m_cnt;            // unbounded count of contended cycles
  logic [DATA_W-1:0] m_rf   [8];       // expected register file contents
  logic [DATA_W-1:0] dut_rf [8];       // register file fed by instance A
  logic [DATA_W-1:0] dutb_rf[8];       // register file fed by instance B

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_rf[i]    = 8'h00;
      dut_rf[i]  = 8'h00;
      dutb_rf[i] = 8'h00;
    end
    m_prio = 1'b0; m_we = 1'b0; m_dest = 3'd0; m_data = 8'h00;
    m_lg = 1'b1; m_cnt = 0;
  end

  // Model state update at each rising edge.
  always @(posedge clk) begin
    int w;
    w = winner(rst, hold, req0_valid, req1_valid, m_prio);
    if (m_we) m_rf[m_dest] <= m_data;
    if (rst) begin
      m_we <= 1'b0; m_dest <= 3'd0; m_data <= 8'h00;
      m_lg <= 1'b1; m_prio <= 1'b0; m_cnt <= 0;
    end else begin
      m_we <= (w >= 0);
      if (w == 0) begin
        m_dest <= req0_dest; m_data <= req0_data; m_lg <= 1'b0; m_prio <= 1'b1;
      end else if (w == 1) begin
        m_dest <= req1_dest; m_data <= req1_data; m_lg <= 1'b1; m_prio <= 1'b0;
      end
      if (req0_valid && req1_valid && !hold) m_cnt <= m_cnt + 1;
    end
  end

  // Register files driven by the DUT write ports.
  always @(posedge clk) begin
    if (a_we) dut_rf[a_dest]  <= a_data;
    if (b_we) dutb_rf[b_dest] <= b_data;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int w;
    w = winner(rst, hold, req0_valid, req1_valid, m_prio);
    check("we_a",   int'(a_we),   int'(m_we));
    check("we_b",   int'(b_we),   int'(m_we));
    check("lg_a",   int'(a_lg),   int'(m_lg));
    check("lg_b",   int'(b_lg),   int'(m_lg));
    check("cnt_a",  int'(a_cnt),  (m_cnt > 255) ? 255 : m_cnt);
    check("cnt_b",  int'(b_cnt),  (m_cnt > 7) ? 7 : m_cnt);
    if (m_we) begin
      check("dest_a", int'(a_dest), int'(m_dest));
      check("data_a", int'(a_data), int'(m_data));
      check("dest_b", int'(b_dest), int'(m_dest));
      check("data_b", int'(b_data), int'(m_data));
    end
    if (req0_valid || rst || hold) begin
      check("ready0_a", int'(a_ready0), int'(w == 0));
      check("ready0_b", int'(b_ready0), int'(w == 0));
    end
    if (req1_valid || rst || hold) begin
      check("ready1_a", int'(a_ready1), int'(w == 1));
      check("ready1_b", int'(b_ready1), int'(w == 1));
    end
    for (int i = 0; i < 8; i++) begin
      check("rf_a", int'(dut_rf[i]),  int'(m_rf[i]));
      check("rf_b", int'(dutb_rf[i]), int'(m_rf[i]));
    end
  end

  // ---------------- directed stimulus ----------------
  // Apply one cycle of inputs, then return 1 time unit after the rising edge.
  task automatic drive(input logic v0, input logic [2:0] d0, input logic [7:0] x0,
                       input logic v1, input logic [2:0] d1, input logic [7:0] x1,
                       input logic h, input logic r);
    req0_valid = v0; req0_dest = d0; req0_data = x0;
    req1_valid = v1; req1_dest = d1; req1_data = x1;
    hold = h; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    req0_valid = 1'b0; req0_dest = 3'd0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_dest = 3'd0; req1_data = 8'h00;

    // Reset then idle.
    do_reset();
    do_reset();
    check("rst_lg",   int'(a_lg),   1);
    check("rst_we",   int'(a_we),   0);
    check("rst_dest", int'(a_dest), 0);
    check("rst_data", int'(a_data), 0);
    check("rst_cnt",  int'(a_cnt),  0);
    idle(10);
    check("idle_we",  int'(a_we),  0);
    check("idle_cnt", int'(a_cnt), 0);

    // Single requester: req0 -> r3 = A5.
    drive(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    check("single_we",   int'(a_we),   1);
    check("single_dest", int'(a_dest), 3);
    check("single_data", int'(a_data), 8'hA5);
    check("single_lg",   int'(a_lg),   0);
    idle(1);
    check("single_rf3",  int'(dut_rf[3]), 8'hA5);

    // Contention on same destination: r5 = 11 then 22.
    do_reset();
    drive(1'b1, 3'd5, 8'h11, 1'b1, 3'd5, 8'h22, 1'b0, 1'b0);
    check("cont_first_lg",   int'(a_lg),   0);
    check("cont_first_data", int'(a_data), 8'h11);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h22, 1'b0, 1'b0);
    check("cont_second_lg",   int'(a_lg),   1);
    check("cont_second_data", int'(a_data), 8'h22);
    idle(1);
    check("cont_rf5", int'(dut_rf[5]), 8'h22);
    check("cont_cnt", int'(a_cnt), 1);

    // Back-to-back contention: alternation 0,1,0,1,...
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'd1, 8'hA0, 1'b1, 3'd2, 8'hB1, 1'b0, 1'b0);
      check("b2b_lg", int'(a_lg), i % 2);
      check("b2b_we", int'(a_we), 1);
    end
    check("b2b_cnt6", int'(a_cnt), 6);
    for (int i = 0; i < 4; i++)
      drive(1'b1, 3'd1, 8'hA0, 1'b1, 3'd2, 8'hB1, 1'b0, 1'b0);
    check("b2b_cnt10_a", int'(a_cnt), 10);
    check("b2b_cnt10_b", int'(b_cnt), 7);
    idle(1);

    // Hold: grant req0 (prio -> 1), then hold 3 cycles with req1 valid.
    do_reset();
    drive(1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h66, 1'b1, 1'b0);
    check("hold_prev_write_lg", int'(a_lg), 0);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h66, 1'b1, 1'b0);
    check("hold_we", int'(a_we), 0);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h66, 1'b1, 1'b0);
    check("hold_we3", int'(a_we), 0);
    check("hold_cnt", int'(a_cnt), 0);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h66, 1'b0, 1'b0);
    check("release_we",   int'(a_we),   1);
    check("release_lg",   int'(a_lg),   1);
    check("release_data", int'(a_data), 8'h66);
    // prio now 0: contended cycle goes to req0.
    drive(1'b1, 3'd7, 8'h77, 1'b1, 3'd0, 8'h0F, 1'b0, 1'b0);
    check("after_hold_lg", int'(a_lg), 0);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h0F, 1'b0, 1'b0);
    check("dest0_write", int'(a_dest), 0);
    idle(2);
    check("rf0", int'(dut_rf[0]), 8'h0F);

    // Reset mid-transfer.
    drive(1'b1, 3'd2, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    check("mid_we", int'(a_we), 1);
    do_reset();
    check("mid_rst_we", int'(a_we), 0);
    check("mid_rst_lg", int'(a_lg), 1);
    drive(1'b1, 3'd1, 8'hC3, 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
    check("mid_prio0_lg", int'(a_lg), 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
